// File: rtl/array_result_drain.sv
// array_result_drain: snapshots a systolic array's PE results on start and streams them out row-major over a valid/ready port.
// Optional feature: define DRAIN_PARITY_EN to add the m_parity output (XOR of m_data).
module array_result_drain #(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int OUTWIDTH = 8,
  localparam int N = ROWS * COLS,
  localparam int IW = (N > 1) ? $clog2(N) : 1,
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [N*OUTWIDTH-1:0] results,
  output logic                  clear_acc,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [OUTWIDTH-1:0]   m_data,
  output logic [RW-1:0]         m_row,
  output logic [CW-1:0]         m_col,
  output logic                  m_last,
`ifdef DRAIN_PARITY_EN
  output logic                  m_parity,
`endif
  output logic                  busy,
  output logic                  start_drop
);
  typedef enum logic {IDLE, STREAM} state_t;
  state_t                state;
  logic [N*OUTWIDTH-1:0] buffer;
  logic [IW-1:0]         idx, nidx;
  logic [RW-1:0]         nrow;
  logic [CW-1:0]         ncol;
  logic [OUTWIDTH-1:0]   ndata;
  logic                  col_end;
  // Next word position: row/column advance as counters so no divider is needed.
  always_comb begin
    nidx = idx + 1'b1;
    col_end = (m_col == CW'(COLS - 1));
    ncol = col_end ? '0 : m_col + 1'b1;
    nrow = col_end ? m_row + 1'b1 : m_row;
    ndata = buffer[nidx*OUTWIDTH +: OUTWIDTH];
  end
  // Drain FSM with all outputs registered; the buffer is frozen for the whole drain.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      buffer <= '0;
      idx <= '0;
      m_valid <= 1'b0;
      m_data <= '0;
      m_row <= '0;
      m_col <= '0;
      m_last <= 1'b0;
      busy <= 1'b0;
      clear_acc <= 1'b0;
      start_drop <= 1'b0;
`ifdef DRAIN_PARITY_EN
      m_parity <= 1'b0;
`endif
    end else begin
      clear_acc <= 1'b0;
      start_drop <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          buffer <= results;
          idx <= '0;
          m_data <= results[OUTWIDTH-1:0];
          m_row <= '0;
          m_col <= '0;
          m_last <= (N == 1);
          m_valid <= 1'b1;
          busy <= 1'b1;
          clear_acc <= 1'b1;
          state <= STREAM;
`ifdef DRAIN_PARITY_EN
          m_parity <= ^results[OUTWIDTH-1:0];
`endif
        end
      end else begin
        start_drop <= start;
        if (m_ready) begin
          if (m_last) begin
            state <= IDLE;
            idx <= '0;
            m_valid <= 1'b0;
            busy <= 1'b0;
            m_last <= 1'b0;
          end else begin
            idx <= nidx;
            m_data <= ndata;
            m_row <= nrow;
            m_col <= ncol;
            m_last <= (nidx == IW'(N - 1));
`ifdef DRAIN_PARITY_EN
            m_parity <= ^ndata;
`endif
          end
        end
      end
    end
  end
endmodule
